// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder.
//   DEFAULT_WIDTH  : default operand/sum width in bits
//   DEFAULT_STAGES : default pipeline depth
//   chunk_width()  : bits added per pipeline stage
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_STAGES = 4;

  // Guarded against a zero stage count so an illegal configuration reaches the
  // elaboration check in pipe_adder instead of a divide-by-zero.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b     : W-bit addends
//   c        : carry in
//   sum      : W-bit sum
//   carryOut : carry out of bit W-1
module adder_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  output logic [W-1:0] sum,
  output logic         carryOut
);

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin : ripple
    logic cy;
    cy  = c;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    carryOut = cy;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: stage k adds chunk k of the operands plus the
// carry from stage k-1. Unprocessed operand chunks travel forward in skew
// registers and finished sum chunks in deskew registers, so every bit of a
// result appears at the output in the same cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   inValid / inReady   : operand handshake (inReady is combinational)
//   a, b, c             : operands and carry in
//   outValid / outReady : result handshake
//   sum, carryOut       : (a + b + c) mod 2^WIDTH and carry out of the MSB
//   overflow            : two's-complement overflow
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) ||
      ((WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Whole pipeline moves together whenever the output slot is free or drained.
  logic adv;
  assign adv     = !outValid || outReady;
  assign inReady = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO  = k * CHUNK;
    localparam int unsigned HI  = LO + CHUNK;
    localparam int unsigned REM = WIDTH - LO;

    logic [REM-1:0]   op_a;
    logic [REM-1:0]   op_b;
    logic             cin;
    logic             vin;
    logic [CHUNK-1:0] ps;
    logic             co;
    logic [HI-1:0]    psum_d;
    logic [HI-1:0]    psum_q;
    logic             carry_q;
    logic             valid_q;

    if (k == 0) begin : g_head
      assign op_a   = a;
      assign op_b   = b;
      assign cin    = c;
      assign vin    = inValid;
      assign psum_d = ps;
    end else begin : g_body
      assign op_a   = g_stage[k-1].g_skew.skew_a_q;
      assign op_b   = g_stage[k-1].g_skew.skew_b_q;
      assign cin    = g_stage[k-1].carry_q;
      assign vin    = g_stage[k-1].valid_q;
      assign psum_d = {ps, g_stage[k-1].psum_q};
    end

    adder_slice #(.W(CHUNK)) u_slice (
      .a        (op_a[CHUNK-1:0]),
      .b        (op_b[CHUNK-1:0]),
      .c        (cin),
      .sum      (ps),
      .carryOut (co)
    );

    // Stage valid bit, carry and deskewed partial sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        psum_q  <= '0;
      end else if (adv) begin
        valid_q <= vin;
        carry_q <= co;
        psum_q  <= psum_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] skew_a_q;
      logic [REM-CHUNK-1:0] skew_b_q;

      // Operand chunks still waiting for their stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          skew_a_q <= '0;
          skew_b_q <= '0;
        end else if (adv) begin
          skew_a_q <= op_a[REM-1:CHUNK];
          skew_b_q <= op_b[REM-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Carry into the MSB is a^b^sum at that bit; XOR with carry out gives overflow.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= op_a[REM-1] ^ op_b[REM-1] ^ ps[CHUNK-1] ^ co;
        end
      end
    end
  end

  assign outValid = g_stage[STAGES-1].valid_q;
  assign sum      = g_stage[STAGES-1].psum_q;
  assign carryOut = g_stage[STAGES-1].carry_q;
  assign overflow = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed vectors and corner sequences on
// an (8,2) instance, then randomized traffic on (8,1), (8,8) and (32,4)
// instances against an arithmetic reference model.
module tb_pipe_adder;

  localparam int N_RND = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, carryOut, sum} for a w-bit add, from plain arithmetic.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input int w);
    logic [32:0] full;
    logic [31:0] mask;
    logic [31:0] s;
    logic        co;
    logic        ov;
    full = 33'(a) + 33'(b) + 33'(c);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // ---------------- main (8,2) instance ----------------
  logic       m_rst, m_iv, m_ir, m_c, m_ov, m_or, m_co, m_ovf;
  logic [7:0] m_a, m_b, m_s;

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_main (
    .clk(clk), .rst(m_rst), .inValid(m_iv), .inReady(m_ir), .a(m_a), .b(m_b), .c(m_c),
    .outValid(m_ov), .outReady(m_or), .sum(m_s), .carryOut(m_co), .overflow(m_ovf)
  );

  // ---------------- random instances ----------------
  logic        r_rst;
  logic        r0_iv, r0_ir, r0_c, r0_ov, r0_or, r0_co, r0_ovf;
  logic [7:0]  r0_a, r0_b, r0_s;
  logic        r1_iv, r1_ir, r1_c, r1_ov, r1_or, r1_co, r1_ovf;
  logic [7:0]  r1_a, r1_b, r1_s;
  logic        r2_iv, r2_ir, r2_c, r2_ov, r2_or, r2_co, r2_ovf;
  logic [31:0] r2_a, r2_b, r2_s;

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_r0 (
    .clk(clk), .rst(r_rst), .inValid(r0_iv), .inReady(r0_ir), .a(r0_a), .b(r0_b), .c(r0_c),
    .outValid(r0_ov), .outReady(r0_or), .sum(r0_s), .carryOut(r0_co), .overflow(r0_ovf)
  );
  pipe_adder #(.WIDTH(8), .STAGES(8)) u_r1 (
    .clk(clk), .rst(r_rst), .inValid(r1_iv), .inReady(r1_ir), .a(r1_a), .b(r1_b), .c(r1_c),
    .outValid(r1_ov), .outReady(r1_or), .sum(r1_s), .carryOut(r1_co), .overflow(r1_ovf)
  );
  pipe_adder #(.WIDTH(32), .STAGES(4)) u_r2 (
    .clk(clk), .rst(r_rst), .inValid(r2_iv), .inReady(r2_ir), .a(r2_a), .b(r2_b), .c(r2_c),
    .outValid(r2_ov), .outReady(r2_or), .sum(r2_s), .carryOut(r2_co), .overflow(r2_ovf)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs [8];

  logic [33:0] q0[$], q1[$], q2[$];
  int          acc [3];
  int          con [3];
  logic        held [3];
  logic [33:0] held_v [3];

  initial begin
    int          idx;
    int          ncons;
    logic [7:0]  hold_s;
    logic        o_iv, o_ir, o_ov, o_or, o_c;
    logic [31:0] o_a, o_b;
    logic [33:0] o_res, exp_res;
    int          w;
    int          qn;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};
    vecs[6] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

    m_rst = 1'b1; m_iv = 1'b0; m_or = 1'b1; m_a = '0; m_b = '0; m_c = 1'b0;
    r_rst = 1'b1;
    r0_iv = 1'b0; r0_or = 1'b0; r0_a = '0; r0_b = '0; r0_c = 1'b0;
    r1_iv = 1'b0; r1_or = 1'b0; r1_a = '0; r1_b = '0; r1_c = 1'b0;
    r2_iv = 1'b0; r2_or = 1'b0; r2_a = '0; r2_b = '0; r2_c = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset outValid", 64'(m_ov), 64'd0);
    chk("reset sum", 64'(m_s), 64'd0);
    chk("reset carryOut", 64'(m_co), 64'd0);
    chk("reset overflow", 64'(m_ovf), 64'd0);
    m_rst = 1'b0;
    #1;
    chk("inReady after reset", 64'(m_ir), 64'd1);

    // Table vectors, one at a time: exact two-cycle latency
    for (int i = 0; i < 8; i++) begin
      m_a = vecs[i].a; m_b = vecs[i].b; m_c = vecs[i].c; m_iv = 1'b1; m_or = 1'b1;
      tick();
      m_iv = 1'b0; m_a = $urandom(); m_b = $urandom();
      chk($sformatf("vec%0d early outValid", i), 64'(m_ov), 64'd0);
      tick();
      chk($sformatf("vec%0d outValid", i), 64'(m_ov), 64'd1);
      chk($sformatf("vec%0d sum", i), 64'(m_s), 64'(vecs[i].s));
      chk($sformatf("vec%0d carryOut", i), 64'(m_co), 64'(vecs[i].co));
      chk($sformatf("vec%0d overflow", i), 64'(m_ovf), 64'(vecs[i].ov));
      tick();
    end

    // Back-to-back stream with outReady low in cycles 3-5
    idx = 0; ncons = 0; hold_s = '0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      m_iv = (idx < 6);
      m_a  = 8'(idx + 1);
      m_b  = 8'h10;
      m_c  = 1'b0;
      m_or = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      chk($sformatf("stream inReady c%0d", cyc), 64'(m_ir), 64'(cyc < 3 || cyc > 5));
      if (cyc == 3) hold_s = m_s;
      if (cyc >= 3 && cyc <= 5) begin
        chk($sformatf("stream hold valid c%0d", cyc), 64'(m_ov), 64'd1);
        chk($sformatf("stream hold sum c%0d", cyc), 64'(m_s), 64'h12);
        chk($sformatf("stream stable c%0d", cyc), 64'(m_s), 64'(hold_s));
      end
      if (m_iv && m_ir) idx++;
      if (m_ov && m_or) begin
        chk($sformatf("stream sum %0d", ncons), 64'(m_s), 64'(32'h11 + ncons));
        ncons++;
      end
      tick();
    end
    m_iv = 1'b0;
    chk("stream accepted", 64'(idx), 64'd6);
    chk("stream consumed", 64'(ncons), 64'd6);

    // Reset while results are in flight
    m_or = 1'b0; m_iv = 1'b1; m_a = 8'h20; m_b = 8'h03; m_c = 1'b0;
    tick();
    m_a = 8'h40; m_b = 8'h05;
    tick();
    chk("flush pre outValid", 64'(m_ov), 64'd1);
    m_iv = 1'b0; m_rst = 1'b1;
    tick();
    m_rst = 1'b0;
    chk("flush outValid", 64'(m_ov), 64'd0);
    chk("flush sum", 64'(m_s), 64'd0);
    chk("flush inReady", 64'(m_ir), 64'd1);
    m_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush idle %0d", i), 64'(m_ov), 64'd0);
    end
    m_iv = 1'b1; m_a = 8'h30; m_b = 8'h04; m_c = 1'b1;
    tick();
    m_iv = 1'b0;
    chk("post-reset early", 64'(m_ov), 64'd0);
    tick();
    chk("post-reset outValid", 64'(m_ov), 64'd1);
    chk("post-reset sum", 64'(m_s), 64'h35);
    chk("post-reset carryOut", 64'(m_co), 64'd0);

    // Randomized traffic on the three extra configurations
    for (int g = 0; g < 3; g++) begin
      acc[g] = 0; con[g] = 0; held[g] = 1'b0; held_v[g] = '0;
    end
    tick();
    r_rst = 1'b0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (con[0] == N_RND && con[1] == N_RND && con[2] == N_RND) break;
      for (int g = 0; g < 3; g++) begin
        logic        iv_n, or_n, c_n;
        logic [31:0] a_n, b_n;
        iv_n = (acc[g] < N_RND) && ($urandom_range(0, 3) != 0);
        or_n = ($urandom_range(0, 3) != 0);
        a_n  = $urandom();
        b_n  = $urandom();
        c_n  = 1'($urandom_range(0, 1));
        case (g)
          0: begin r0_iv = iv_n; r0_or = or_n; r0_a = a_n[7:0]; r0_b = b_n[7:0]; r0_c = c_n; end
          1: begin r1_iv = iv_n; r1_or = or_n; r1_a = a_n[7:0]; r1_b = b_n[7:0]; r1_c = c_n; end
          default: begin r2_iv = iv_n; r2_or = or_n; r2_a = a_n; r2_b = b_n; r2_c = c_n; end
        endcase
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        case (g)
          0: begin
            o_iv = r0_iv; o_ir = r0_ir; o_ov = r0_ov; o_or = r0_or; o_c = r0_c; w = 8;
            o_a = 32'(r0_a); o_b = 32'(r0_b); o_res = {r0_ovf, r0_co, 32'(r0_s)}; qn = q0.size();
          end
          1: begin
            o_iv = r1_iv; o_ir = r1_ir; o_ov = r1_ov; o_or = r1_or; o_c = r1_c; w = 8;
            o_a = 32'(r1_a); o_b = 32'(r1_b); o_res = {r1_ovf, r1_co, 32'(r1_s)}; qn = q1.size();
          end
          default: begin
            o_iv = r2_iv; o_ir = r2_ir; o_ov = r2_ov; o_or = r2_or; o_c = r2_c; w = 32;
            o_a = r2_a; o_b = r2_b; o_res = {r2_ovf, r2_co, r2_s}; qn = q2.size();
          end
        endcase
        chk($sformatf("rnd%0d inReady", g), 64'(o_ir), 64'(!o_ov || o_or));
        if (held[g]) begin
          chk($sformatf("rnd%0d hold valid", g), 64'(o_ov), 64'd1);
          chk($sformatf("rnd%0d hold data", g), 64'(o_res), 64'(held_v[g]));
        end
        if (o_ov && o_or) begin
          if (qn == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rnd%0d spurious result: got 0x%0h, want none", g, o_res);
          end else begin
            case (g)
              0: exp_res = q0.pop_front();
              1: exp_res = q1.pop_front();
              default: exp_res = q2.pop_front();
            endcase
            chk($sformatf("rnd%0d result %0d", g, con[g]), 64'(o_res), 64'(exp_res));
          end
          con[g]++;
        end
        if (o_iv && o_ir) begin
          case (g)
            0: q0.push_back(ref_add(o_a, o_b, o_c, w));
            1: q1.push_back(ref_add(o_a, o_b, o_c, w));
            default: q2.push_back(ref_add(o_a, o_b, o_c, w));
          endcase
          acc[g]++;
        end
        held[g]   = o_ov && !o_or;
        held_v[g] = o_res;
      end
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rnd%0d accepted", g), 64'(acc[g]), 64'(N_RND));
      chk($sformatf("rnd%0d consumed", g), 64'(con[g]), 64'(N_RND));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
